// File: rtl/enc_sym_pkg.sv
// rtl/enc_sym_pkg.sv - shared states, token layout and constants for the JPEG symbol encoder
package enc_sym_pkg;

    localparam int BLOCK_LEN = 64;
    localparam int COEF_W    = 16;
    localparam int AMP_W     = 16;
    localparam int TOKEN_W   = 24;

    localparam int RUN_LSB  = 20;
    localparam int SIZE_LSB = 16;
    localparam int AMP_LSB  = 0;

    localparam logic [7:0] RS_ZRL = 8'hF0;
    localparam logic [7:0] RS_EOB = 8'h00;

    typedef enum logic [2:0] {
        S_DC,
        S_AC,
        S_ZRL,
        S_EOB,
        S_EOS
    } encState;

    function automatic logic [TOKEN_W-1:0] makeToken(input logic [3:0] run,
                                                     input logic [3:0] size,
                                                     input logic [AMP_W-1:0] amp);
        logic [TOKEN_W-1:0] tok;
        tok = '0;
        tok[RUN_LSB +: 4]     = run;
        tok[SIZE_LSB +: 4]    = size;
        tok[AMP_LSB +: AMP_W] = amp;
        return tok;
    endfunction

endpackage

// File: rtl/enc_sym_magcat.sv
// rtl/enc_sym_magcat.sv - JPEG magnitude category and amplitude bits of a 17-bit signed value
module enc_sym_magcat
    import enc_sym_pkg::*;
(
    input  logic signed [16:0]      value,
    output logic        [3:0]       size,
    output logic        [AMP_W-1:0] amp
);

    logic [16:0] mag;
    logic [4:0]  sizeFull;
    logic [15:0] mask;

    always_comb begin
        mag      = value[16] ? -value : value;
        sizeFull = 5'd0;
        for (int i = 0; i < 17; i++) begin
            if (mag[i]) sizeFull = 5'(i + 1);
        end
        size = sizeFull[3:0];
        mask = 16'((17'd1 << sizeFull) - 17'd1);
        // Negative values carry the one's complement of |x|, i.e. (x-1) trimmed to size bits.
        amp  = value[16] ? (16'(value - 17'sd1) & mask) : value[15:0];
    end

endmodule

// File: rtl/enc_sym_rle.sv
// rtl/enc_sym_rle.sv - zigzag coefficients to JPEG DC/AC/ZRL/EOB symbol tokens
module enc_sym_rle
    import enc_sym_pkg::*;
(
    input  logic                clock,
    input  logic                reset,
    input  logic [COEF_W-1:0]   coefToken_d,
    input  logic                coefToken_e,
    input  logic                coefToken_v,
    output logic                coefToken_b,
    output logic [TOKEN_W-1:0]  encToken_d,
    output logic                encToken_e,
    output logic                encToken_v,
    input  logic                encToken_b
);

    encState state, stateNext;

    logic [5:0]              idx;
    logic [5:0]              run;
    logic signed [COEF_W-1:0] pred;
    logic signed [COEF_W-1:0] held;
    logic                    heldLast;
    logic                    eosPending;

    logic                    accept, outFree, isZero, lastIdx, runBig;
    logic signed [16:0]      diff, magIn;
    logic [3:0]              magSize;
    logic [AMP_W-1:0]        magAmp;
    logic                    emit, emitE;
    logic [TOKEN_W-1:0]      emitD;

    assign coefToken_b = reset | (encToken_v & encToken_b)
                       | (state == S_ZRL) | (state == S_EOB) | (state == S_EOS);
    assign accept  = coefToken_v & ~coefToken_b;
    assign outFree = ~encToken_v | ~encToken_b;
    assign isZero  = (coefToken_d == '0);
    assign lastIdx = (idx == 6'(BLOCK_LEN - 1));
    assign runBig  = (run[5:4] != 2'b00);
    assign diff    = $signed({coefToken_d[COEF_W-1], coefToken_d}) - $signed({pred[COEF_W-1], pred});

    enc_sym_magcat uMagcat (
        .value (magIn),
        .size  (magSize),
        .amp   (magAmp)
    );

    always_ff @(posedge clock) begin
        if (reset) state <= S_DC;
        else       state <= stateNext;
    end

    always_comb begin
        stateNext = state;
        case (state)
            S_DC:  if (accept) stateNext = coefToken_e ? S_EOS : S_AC;
            S_AC:  if (accept) begin
                       if (coefToken_e)        stateNext = S_EOB;
                       else if (isZero)        stateNext = lastIdx ? S_EOB : S_AC;
                       else if (runBig)        stateNext = S_ZRL;
                       else if (lastIdx)       stateNext = S_DC;
                   end
            S_ZRL: if (outFree && !runBig) stateNext = heldLast ? S_DC : S_AC;
            S_EOB: if (outFree) stateNext = eosPending ? S_EOS : S_DC;
            S_EOS: if (outFree) stateNext = S_DC;
            default: stateNext = S_DC;
        endcase
    end

    always_comb begin
        magIn = {coefToken_d[COEF_W-1], coefToken_d};
        emit  = 1'b0;
        emitE = 1'b0;
        emitD = '0;
        case (state)
            S_DC: begin
                magIn = diff;
                emit  = accept & ~coefToken_e;
                emitD = makeToken(4'h0, magSize, magAmp);
            end
            S_AC: begin
                emit  = accept & ~coefToken_e & ~isZero & ~runBig;
                emitD = makeToken(run[3:0], magSize, magAmp);
            end
            S_ZRL: begin
                magIn = {held[COEF_W-1], held};
                emit  = outFree;
                emitD = runBig ? {RS_ZRL, 16'h0000} : makeToken(run[3:0], magSize, magAmp);
            end
            S_EOB: begin
                emit  = outFree;
                emitD = {RS_EOB, 16'h0000};
            end
            S_EOS: begin
                emit  = outFree;
                emitE = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            encToken_v <= 1'b0;
            encToken_e <= 1'b0;
            encToken_d <= '0;
            idx        <= '0;
            run        <= '0;
            pred       <= '0;
            held       <= '0;
            heldLast   <= 1'b0;
            eosPending <= 1'b0;
        end else begin
            if (emit) begin
                encToken_v <= 1'b1;
                encToken_e <= emitE;
                encToken_d <= emitD;
            end else if (encToken_v && !encToken_b) begin
                encToken_v <= 1'b0;
            end
            case (state)
                S_DC: if (accept && !coefToken_e) begin
                    pred <= coefToken_d;
                    idx  <= 6'd1;
                    run  <= '0;
                end
                S_AC: if (accept) begin
                    if (coefToken_e) begin
                        eosPending <= 1'b1;
                    end else begin
                        // Wraps to 0 after index 63, ready for the next DC.
                        idx <= idx + 6'd1;
                        if (isZero) begin
                            if (!lastIdx) run <= run + 6'd1;
                        end else if (runBig) begin
                            held     <= coefToken_d;
                            heldLast <= lastIdx;
                        end else begin
                            run <= '0;
                        end
                    end
                end
                S_ZRL: if (outFree) run <= runBig ? run - 6'd16 : 6'd0;
                S_EOB: if (outFree) begin
                    idx        <= '0;
                    run        <= '0;
                    eosPending <= 1'b0;
                end
                S_EOS: if (outFree) pred <= '0;
                default: ;
            endcase
        end
    end

endmodule

// File: doc/enc_sym_rle.md
Name: enc_sym_rle

Overview:
- Encoder-side counterpart of the JPEG symbol decoder page.
- Consumes zigzag-ordered quantized coefficients, 64 per block, on a d/e/v/b stream.
- Emits JPEG entropy-coder symbols: DC difference category and amplitude, AC (run,size) plus amplitude, ZRL, EOB, as 24-bit tokens on a d/e/v/b stream.
- Sits between quantizer/zigzag and the Huffman bit packer.

Parameters:
BLOCK_LEN, 64, coefficients per block (index 0 = DC)
COEF_W, 16, signed coefficient width
AMP_W, 16, amplitude field width in output token

Ports:
clock  input  1  single clock
reset  input  1  synchronous, active-high reset
coefToken_d  input  16  signed coefficient, two's complement; legal range ±2047
coefToken_e  input  1  end-of-stream marker, qualified by coefToken_v; data ignored
coefToken_v  input  1  token valid
coefToken_b  output  1  back-pressure to producer
encToken_d  output  24  [23:20] run, [19:16] size, [15:0] amplitude bits
encToken_e  output  1  end-of-stream marker, qualified by encToken_v
encToken_v  output  1  output token valid
encToken_b  input  1  back-pressure from consumer

Behaviour:
- Clock and reset: one clock (clock). reset is synchronous and active-high.
- Transfer rule: a token moves when v=1 and b=0 in the same cycle.
- Reset values:
  - encToken_v=0, encToken_e=0, encToken_d=0, coefToken_b=1 for the reset cycle only.
  - state=S_DC, idx=0, run=0, pred=0.
  - Reset mid-block discards all partial state; no token is emitted.
- Output register: one entry. d, e and v are held stable while encToken_b=1. The register reloads in the cycle it drains.
- Input back-pressure: coefToken_b = (encToken_v & encToken_b) | (state in {S_ZRL, S_EOB, S_EOS}).
- Latency and throughput: accepted input to encToken_v is 1 cycle. Throughput is 1 token/cycle with no stall.
- Size rule: size(x) = bit length of |x|; size(0)=0.
- Amplitude rule:
  - x>0: amp = x.
  - x<0: amp = (x-1) masked to size bits (one's complement).
  - Upper amplitude bits are zero.
- S_DC:
  - Accepted coefficient c: diff = c - pred, computed 17-bit. Emit {0, size(diff), amp(diff)}. pred <= c, idx <= 1, go to S_AC.
  - Accepted eos: go to S_EOS.
- S_AC, accepted coefficient c:
  - c==0 and idx<63: run++.
  - c==0 and idx==63: go to S_EOB. Trailing run is dropped; no ZRL for it.
  - c!=0 and run>=16: hold c, go to S_ZRL.
  - c!=0 and run<16: emit {run, size(c), amp(c)}, run <= 0.
  - idx increments on each accepted coefficient. After accepting idx 63 with c!=0, go to S_DC with no EOB.
  - Accepted eos in S_AC: go to S_EOB, then S_EOS.
- S_ZRL: each cycle the output register is free, emit 0xF0_0000 and run -= 16. When run<16, emit the held coefficient symbol, run <= 0, and return to S_AC, or to S_DC if the held coefficient was idx 63.
- S_EOB: emit 0x00_0000, idx <= 0, run <= 0. Next state is S_DC, or S_EOS if entered via eos.
- S_EOS: emit a token with encToken_e=1, d=0. pred <= 0, go to S_DC.
- Simultaneous events: a drain and a reload in the same cycle are legal and lose no token. An input offered while coefToken_b=1 is neither consumed nor counted.

Decomposition:
- Shared package enc_sym_pkg:
  - state enum S_DC, S_AC, S_ZRL, S_EOB, S_EOS.
  - constants RS_ZRL=8'hF0, RS_EOB=8'h00, token field offsets.
- One natural sub-module, enc_sym_magcat: combinational size and amplitude computation for a 17-bit signed input. It is instantiated once, muxed between diff and c.

Test Plan:
- After reset, block with DC=50 and AC all 0 -> tokens 0x06_0032 then 0x00_0000 (EOB). Next block DC=45 -> diff -5 -> 0x03_0002, then EOB.
- Block with AC idx1–20 = 0, idx21 = 3, rest 0 -> DC token, 0xF0_0000 (ZRL), 0x42_0003, 0x00_0000. Exactly 4 tokens.
- Block with AC idx1–63 all = -1 -> DC token plus 63 tokens of 0x01_0000, no EOB. Next block starts in S_DC.
- Hold encToken_b=1 for 5 cycles mid-block -> encToken_d/v stable and coefToken_b=1 throughout. Token sequence is identical to the unstalled run; 1 token/cycle after release.
- eos after AC idx10 -> EOB 0x00_0000, then token with e=1, v=1. Following block DC=50 -> 0x06_0032, confirming pred reset.
- Assert reset at AC idx30 with encToken_v=1 -> encToken_v=0 next cycle. Next block emits its DC token with pred=0.
